branch_decode_ctrl: RTL and testbench

- Decode-stage partner of the instruction fetch stage. It consumes the fetched instruction and PC into an IF/ID register, decodes LEGv8 branches, and drives the fetch stage's next-PC controls (brTaken, uncondBr, condAddr19, condAddr26, forward target).
- One architectural branch delay slot; no flush.
- Stalls on flag and operand hazards. During a stall it re-targets fetch to its own current PC, so the PC holds without a PC enable.

---
 rtl/branch_pkg.sv | 48 ++++
 rtl/branch_decode_ctrl_cond_eval.sv | 32 +++
 rtl/branch_decode_ctrl_dff.sv | 25 ++
 rtl/branch_decode_ctrl.sv | 144 ++++++++++++++
 tb/tb_branch_decode_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the LEGv8 branch decode stage: opcodes, condition
// codes, reset instruction and the enums used by the decode controller.
package branch_pkg;

  localparam logic [31:0] NOP_WORD = 32'h8B1F03FF;  // ADD XZR,XZR,XZR

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_BR    = 11'b11010110000;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;

  typedef enum logic [1:0] {
    BR_SEQ = 2'b00,
    BR_REL = 2'b01,
    BR_ABS = 2'b10
  } br_sel_e;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    WAIT_FLAGS = 2'b01,
    WAIT_OPND  = 2'b10
  } state_e;

  typedef struct packed {
    logic is_b;      // B or BL
    logic is_cbz;
    logic is_bcond;
    logic is_br;
  } br_kind_t;

  function automatic br_kind_t decode_branch(input logic [31:0] insn);
    br_kind_t k;
    k.is_b     = (insn[31:26] == OP_B) || (insn[31:26] == OP_BL);
    k.is_cbz   = (insn[31:24] == OP_CBZ);
    k.is_bcond = (insn[31:24] == OP_BCOND);
    k.is_br    = (insn[31:21] == OP_BR);
    return k;
  endfunction

endpackage

// File: rtl/branch_decode_ctrl_cond_eval.sv
// Evaluates a B.cond condition code against the NZVC flags. Only the
// signed/equality conditions are supported; everything else is not taken.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  input  logic       c,
  output logic       taken
);

  // The condition table uses no carry term, so C feeds only this sink.
  logic carry_unused;
  assign carry_unused = c;

  // Condition table lookup.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_decode_ctrl_dff.sv
// Parametrised D flip-flop bank with load enable and asynchronous
// active-low reset to a configurable value.
module branch_decode_ctrl_dff #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/branch_decode_ctrl.sv
// Decode-stage branch controller: owns the IF/ID register, decodes LEGv8
// branches and steers the fetch stage's next-PC mux. Hazards stall by
// pointing fetch back at its own PC rather than gating the PC register.
module branch_decode_ctrl #(
  parameter logic [31:0] NOP_WORD = branch_pkg::NOP_WORD,
  parameter int          PC_W     = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic [PC_W-1:0] pc_in,
  input  logic            flagWriteEX,
  input  logic            aluNeg,
  input  logic            aluZero,
  input  logic            aluOvf,
  input  logic            aluCarry,
  input  logic [PC_W-1:0] rtValue,
  input  logic            rtValid,
  output logic [1:0]      brTaken,
  output logic            uncondBr,
  output logic [18:0]     condAddr19,
  output logic [25:0]     condAddr26,
  output logic [PC_W-1:0] forwardCtrlOneOutput,
  output logic [31:0]     ifid_instruction,
  output logic [PC_W-1:0] ifid_pc,
  output logic            stall
);

  import branch_pkg::*;

  logic [31+PC_W:0] ifid_q_s;
  logic [31:0]      ifid_instr_r;
  logic [PC_W-1:0]  ifid_pc_r;
  br_kind_t         kind_s;
  logic             cond_hit_s;
  logic             cond_taken_s;
  logic             flag_hazard_s;
  logic             opnd_hazard_s;
  logic             hold_s;
  state_e           state_r;
  state_e           state_nxt_s;
  br_sel_e          br_sel_s;
  logic             uncond_s;
  logic [PC_W-1:0]  fwd_s;

  branch_decode_ctrl_dff #(
    .W       (32 + PC_W),
    .RST_VAL ({NOP_WORD, {PC_W{1'b0}}})
  ) u_ifid (
    .clk   (clk),
    .reset (reset),
    .en    (!hold_s),
    .d     ({instruction, pc_in}),
    .q     (ifid_q_s)
  );

  assign ifid_instr_r = ifid_q_s[31+PC_W:PC_W];
  assign ifid_pc_r    = ifid_q_s[PC_W-1:0];
  assign kind_s       = decode_branch(ifid_instr_r);

  cond_eval u_cond (
    .cond  (ifid_instr_r[3:0]),
    .n     (aluNeg),
    .z     (aluZero),
    .v     (aluOvf),
    .c     (aluCarry),
    .taken (cond_hit_s)
  );

  // cond[4] set is outside the supported table, so it never branches.
  assign cond_taken_s  = cond_hit_s && !ifid_instr_r[4];
  assign flag_hazard_s = kind_s.is_bcond && flagWriteEX;
  assign opnd_hazard_s = (kind_s.is_cbz || kind_s.is_br) && !rtValid;
  // WAIT_FLAGS deliberately never stalls: the flags are final by then.
  assign hold_s = ((state_r == RUN) && (flag_hazard_s || opnd_hazard_s)) ||
                  ((state_r == WAIT_OPND) && !rtValid);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: remember which hazard is being waited out.
  always_comb begin
    state_nxt_s = RUN;
    case (state_r)
      RUN: begin
        if (flag_hazard_s) begin
          state_nxt_s = WAIT_FLAGS;
        end else if (opnd_hazard_s) begin
          state_nxt_s = WAIT_OPND;
        end else begin
          state_nxt_s = RUN;
        end
      end
      WAIT_FLAGS: state_nxt_s = RUN;
      WAIT_OPND: begin
        if (!rtValid) begin
          state_nxt_s = WAIT_OPND;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Next-PC steering: hold fetch on a stall, otherwise resolve the branch.
  always_comb begin
    br_sel_s = BR_SEQ;
    uncond_s = 1'b0;
    fwd_s    = {PC_W{1'b0}};
    if (hold_s) begin
      br_sel_s = BR_ABS;
      fwd_s    = pc_in;
    end else if (kind_s.is_b) begin
      br_sel_s = BR_REL;
      uncond_s = 1'b1;
    end else if (kind_s.is_cbz) begin
      br_sel_s = (rtValue == {PC_W{1'b0}}) ? BR_REL : BR_SEQ;
    end else if (kind_s.is_bcond) begin
      br_sel_s = cond_taken_s ? BR_REL : BR_SEQ;
    end else if (kind_s.is_br) begin
      br_sel_s = BR_ABS;
      fwd_s    = rtValue;
    end else begin
      br_sel_s = BR_SEQ;
    end
  end

  assign brTaken              = br_sel_s;
  assign uncondBr             = uncond_s;
  assign forwardCtrlOneOutput = fwd_s;
  assign stall                = hold_s;
  assign condAddr19           = ifid_instr_r[23:5];
  assign condAddr26           = ifid_instr_r[25:0];
  assign ifid_instruction     = ifid_instr_r;
  assign ifid_pc              = ifid_pc_r;

endmodule

// File: tb/tb_branch_decode_ctrl.sv
// Scoreboard bench for branch_decode_ctrl: the stimulus process predicts each
// cycle's outputs from a behavioural model and queues them; a monitor on the
// falling edge pops and compares.
module tb_branch_decode_ctrl;

  localparam logic [31:0] NOP = 32'h8B1F03FF;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [63:0] pc_in;
  logic        flagWriteEX;
  logic        aluNeg, aluZero, aluOvf, aluCarry;
  logic [63:0] rtValue;
  logic        rtValid;
  logic [1:0]  brTaken;
  logic        uncondBr;
  logic [18:0] condAddr19;
  logic [25:0] condAddr26;
  logic [63:0] forwardCtrlOneOutput;
  logic [31:0] ifid_instruction;
  logic [63:0] ifid_pc;
  logic        stall;

  branch_decode_ctrl dut (
    .clk(clk), .reset(reset), .instruction(instruction), .pc_in(pc_in),
    .flagWriteEX(flagWriteEX), .aluNeg(aluNeg), .aluZero(aluZero),
    .aluOvf(aluOvf), .aluCarry(aluCarry), .rtValue(rtValue), .rtValid(rtValid),
    .brTaken(brTaken), .uncondBr(uncondBr), .condAddr19(condAddr19),
    .condAddr26(condAddr26), .forwardCtrlOneOutput(forwardCtrlOneOutput),
    .ifid_instruction(ifid_instruction), .ifid_pc(ifid_pc), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  br;
    logic        unc;
    logic [63:0] fwd;
    logic        stl;
    logic [31:0] ii;
    logic [63:0] ip;
  } exp_t;

  exp_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  // Model of the decode stage: the instruction sitting in decode, its PC,
  // and which hazard (if any) was being waited on last cycle.
  logic [31:0] m_instr = NOP;
  logic [63:0] m_pc    = 64'd0;
  int          m_wait  = 0;      // 0 none, 1 flags just settled, 2 operand
  logic [31:0] p_instr = NOP;
  logic [63:0] p_pc    = 64'd0;
  logic        p_stall = 1'b0;
  int          p_wait  = 0;
  logic        p_rst   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: the DUT presents a decision every cycle; compare it mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("brTaken",  {62'd0, brTaken}, {62'd0, e.br});
      chk("uncondBr", {63'd0, uncondBr}, {63'd0, e.unc});
      chk("fwd",      forwardCtrlOneOutput, e.fwd);
      chk("stall",    {63'd0, stall}, {63'd0, e.stl});
      chk("ifid_ins", {32'd0, ifid_instruction}, {32'd0, e.ii});
      chk("ifid_pc",  ifid_pc, e.ip);
      chk("addr19",   {45'd0, condAddr19}, {45'd0, e.ii[23:5]});
      chk("addr26",   {38'd0, condAddr26}, {38'd0, e.ii[25:0]});
    end
  end

  function automatic logic cond_holds(input logic [4:0] cc, input logic [3:0] nzvc);
    logic n, z, v;
    n = nzvc[3]; z = nzvc[2]; v = nzvc[1];
    case (cc)
      5'd0:  return z;
      5'd1:  return !z;
      5'd10: return n == v;
      5'd11: return n != v;
      5'd12: return !z && (n == v);
      5'd13: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  // One clock of stimulus: retire the previous cycle into the model, drive
  // new inputs, predict the outputs for this cycle and queue them.
  task automatic step(input logic rst, input logic [31:0] ins, input logic [63:0] pc,
                      input logic fwe, input logic [3:0] nzvc,
                      input logic [63:0] rv, input logic rvalid);
    exp_t e;
    logic is_b, is_cbz, is_bc, is_br, need_flags, need_opnd;
    @(posedge clk);
    if (p_rst) begin
      if (!p_stall) begin
        m_instr = p_instr;
        m_pc    = p_pc;
      end
      m_wait = p_wait;
    end
    #1;
    reset = rst; instruction = ins; pc_in = pc; flagWriteEX = fwe;
    {aluNeg, aluZero, aluOvf, aluCarry} = nzvc;
    rtValue = rv; rtValid = rvalid;
    if (!rst) begin
      m_instr = NOP; m_pc = 64'd0; m_wait = 0;
    end
    is_b   = (m_instr[31:26] == 6'h05) || (m_instr[31:26] == 6'h25);
    is_cbz = (m_instr[31:24] == 8'hB4);
    is_bc  = (m_instr[31:24] == 8'h54);
    is_br  = (m_instr[31:21] == 11'h6B0);
    need_flags = is_bc && fwe && (m_wait != 1);
    need_opnd  = (is_cbz || is_br) && !rvalid;
    e.ii = m_instr; e.ip = m_pc; e.unc = 1'b0; e.fwd = 64'd0; e.br = 2'b00; e.stl = 1'b0;
    p_wait = 0;
    if (need_flags || need_opnd) begin
      e.stl = 1'b1; e.br = 2'b10; e.fwd = pc;
      p_wait = need_flags ? 1 : 2;
    end else if (is_b) begin
      e.br = 2'b01; e.unc = 1'b1;
    end else if (is_cbz) begin
      e.br = (rv == 64'd0) ? 2'b01 : 2'b00;
    end else if (is_bc) begin
      e.br = cond_holds(m_instr[4:0], nzvc) ? 2'b01 : 2'b00;
    end else if (is_br) begin
      e.br = 2'b10; e.fwd = rv;
    end
    exp_q.push_back(e);
    p_instr = ins; p_pc = pc; p_stall = e.stl; p_rst = rst;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] r;
    logic [4:0]  c5;
    r  = $urandom;
    c5 = r[4:0];
    case ($urandom_range(0, 5))
      0: return {($urandom_range(0, 1) == 1) ? 6'h25 : 6'h05, r[25:0]};
      1: return {8'hB4, r[23:0]};
      2: return {8'h54, r[23:5], (($urandom_range(0, 3) == 0) ? c5 : {1'b0, c5[3:0]})};
      3: return {11'h6B0, r[20:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    logic [63:0] rv;
    reset = 1'b0; instruction = $urandom; pc_in = {$urandom, $urandom};
    flagWriteEX = 1'b1; {aluNeg, aluZero, aluOvf, aluCarry} = 4'hF;
    rtValue = 64'd7; rtValid = 1'b0;

    // Reset with random inputs.
    step(1'b0, $urandom, {$urandom, $urandom}, 1'b1, 4'($urandom), 64'd9, 1'b0);
    step(1'b0, $urandom, {$urandom, $urandom}, 1'b0, 4'($urandom), 64'd0, 1'b1);

    // Unconditional branch B #3 at 0x40, then sequential.
    step(1'b1, 32'h14000003, 64'h40, 1'b0, 4'h0, 64'd0, 1'b1);
    step(1'b1, NOP,          64'h44, 1'b0, 4'h0, 64'd0, 1'b1);
    step(1'b1, NOP,          64'h48, 1'b0, 4'h0, 64'd0, 1'b1);
    step(1'b1, NOP,          64'h4C, 1'b0, 4'h0, 64'd0, 1'b1);

    // B.EQ behind a flag-setting instruction.
    step(1'b1, 32'h54000040, 64'h100, 1'b0, 4'h0, 64'd0, 1'b1);
    step(1'b1, NOP,          64'h104, 1'b1, 4'h0, 64'd0, 1'b1);
    step(1'b1, NOP,          64'h104, 1'b1, 4'h4, 64'd0, 1'b1);
    step(1'b1, NOP,          64'h108, 1'b0, 4'h0, 64'd0, 1'b1);

    // CBZ load-use, taken then not taken.
    for (int k = 0; k < 2; k++) begin
      rv = (k == 0) ? 64'd0 : 64'd5;
      step(1'b1, 32'hB4000041, 64'h200, 1'b0, 4'h0, 64'd1, 1'b1);
      step(1'b1, NOP,          64'h204, 1'b0, 4'h0, 64'd1, 1'b0);
      step(1'b1, NOP,          64'h204, 1'b0, 4'h0, 64'd1, 1'b0);
      step(1'b1, NOP,          64'h204, 1'b0, 4'h0, rv,    1'b1);
      step(1'b1, NOP,          64'h208, 1'b0, 4'h0, 64'd0, 1'b1);
    end

    // BR X1 to 0x1000.
    step(1'b1, 32'hD61F0020, 64'h300, 1'b0, 4'h0, 64'd0,    1'b1);
    step(1'b1, NOP,          64'h304, 1'b0, 4'h0, 64'h1000, 1'b1);

    // Condition sweep: every cond against every NZVC pattern.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        step(1'b1, {8'h54, 19'd1, 5'(c)}, 64'h400, 1'b0, 4'h0, 64'd0, 1'b1);
        step(1'b1, NOP, 64'h404, 1'b0, 4'(f), 64'd0, 1'b1);
      end
    end

    // Async reset while waiting on an operand.
    step(1'b1, 32'hB4000041, 64'h500, 1'b0, 4'h0, 64'd3, 1'b1);
    step(1'b1, NOP,          64'h504, 1'b0, 4'h0, 64'd3, 1'b0);
    step(1'b1, NOP,          64'h504, 1'b0, 4'h0, 64'd3, 1'b0);
    step(1'b0, NOP,          64'h504, 1'b0, 4'h0, 64'd3, 1'b0);
    step(1'b1, 32'hB4000041, 64'h600, 1'b0, 4'h0, 64'd3, 1'b0);
    step(1'b1, NOP,          64'h604, 1'b0, 4'h0, 64'd0, 1'b0);
    step(1'b1, NOP,          64'h604, 1'b0, 4'h0, 64'd0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
      step(($urandom_range(0, 199) != 0), rand_insn(), {$urandom, $urandom},
           ($urandom_range(0, 2) == 0), 4'($urandom), rv,
           ($urandom_range(0, 3) != 0));
    end

    repeat (2) @(posedge clk);
    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
